// File: rtl/wb_scoreboard.sv
// Writeback result FIFO with a per-register pending scoreboard.
// Drains one queued result per cycle onto the register file write port.
module wb_scoreboard #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   iss_valid,
  input  logic                   iss_wr,
  input  logic [ADDR_W-1:0]      iss_dest,
  input  logic [ADDR_W-1:0]      iss_src1,
  input  logic [ADDR_W-1:0]      iss_src2,
  output logic                   hazard,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic [ADDR_W-1:0]      res_dest,
  input  logic [DATA_W-1:0]      res_val,
  output logic                   write_enable,
  output logic [ADDR_W-1:0]      dest,
  output logic [DATA_W-1:0]      destVal,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int NR = 1 << ADDR_W;

  logic [ADDR_W-1:0] dmem_q [DEPTH];
  logic [DATA_W-1:0] vmem_q [DEPTH];

  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic [NR-1:0]     pend_q, pend_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] val_q, val_d;

  logic              push, pop, iss_set;
  logic [ADDR_W-1:0] head_dest;
  logic [DATA_W-1:0] head_val;

  assign head_dest = dmem_q[rptr_q];
  assign head_val  = vmem_q[rptr_q];

  assign res_ready = cnt_q < (PW+1)'(DEPTH);
  assign push      = res_valid && res_ready;
  assign pop       = cnt_q != '0;

  // pend_q[0] is held at zero, so r0 sources never stall
  assign hazard = (iss_src1 != '0 && pend_q[iss_src1])
                | (iss_src2 != '0 && pend_q[iss_src2])
                | (iss_wr && iss_dest != '0 && pend_q[iss_dest]);

  assign iss_set = iss_valid && !hazard && iss_wr && iss_dest != '0;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    pend_d = pend_q;
    we_d   = 1'b0;
    dest_d = dest_q;
    val_d  = val_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop) begin
      rptr_d            = rptr_q + PW'(1);
      pend_d[head_dest] = 1'b0;
      we_d              = head_dest != '0;
      dest_d            = head_dest;
      val_d             = head_val;
    end
    if (iss_set) pend_d[iss_dest] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      pend_q <= '0;
      we_q   <= 1'b0;
      dest_q <= '0;
      val_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      we_q   <= we_d;
      dest_q <= dest_d;
      val_q  <= val_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      dmem_q[wptr_q] <= res_dest;
      vmem_q[wptr_q] <= res_val;
    end
  end

  assign write_enable = we_q;
  assign dest         = dest_q;
  assign destVal      = val_q;
  assign fifo_count   = cnt_q;
endmodule

// File: tb/tb_wb_scoreboard.sv
// Randomized scoreboard bench for wb_scoreboard.
// Queue-based reference model; negedge monitor checks every cycle.
module tb_wb_scoreboard;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          iss_valid, iss_wr;
  logic [AW-1:0] iss_dest, iss_src1, iss_src2;
  logic          hazard;
  logic          res_valid, res_ready;
  logic [AW-1:0] res_dest;
  logic [DW-1:0] res_val;
  logic          write_enable;
  logic [AW-1:0] dest;
  logic [DW-1:0] destVal;
  logic [2:0]    fifo_count;

  always #5 clk = ~clk;

  wb_scoreboard #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_wr(iss_wr),
    .iss_dest(iss_dest), .iss_src1(iss_src1), .iss_src2(iss_src2),
    .hazard(hazard),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_dest(res_dest), .res_val(res_val),
    .write_enable(write_enable), .dest(dest), .destVal(destVal),
    .fifo_count(fifo_count)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] d;
    logic [DW-1:0] v;
  } res_t;

  res_t          mq[$];
  res_t          sbq[$];
  bit [31:0]     pend;
  bit            m_we;
  logic [AW-1:0] m_dest;
  logic [DW-1:0] m_val;
  bit            armed = 0;
  bit            acc, ok_iss;
  res_t          h;

  function automatic bit m_haz(bit [31:0] p, logic wr,
                               logic [AW-1:0] d, logic [AW-1:0] s1,
                               logic [AW-1:0] s2);
    return (s1 != 0 && p[s1]) || (s2 != 0 && p[s2])
        || (wr && d != 0 && p[d]);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      sbq.delete();
      pend   = '0;
      m_we   = 0;
      m_dest = '0;
      m_val  = '0;
      armed  = 1;
    end else if (armed) begin
      acc    = res_valid && mq.size() < DEPTH;
      ok_iss = iss_valid && iss_wr && iss_dest != 0
            && !m_haz(pend, iss_wr, iss_dest, iss_src1, iss_src2);
      m_we = 0;
      if (mq.size() > 0) begin
        h       = mq.pop_front();
        m_we    = h.d != 0;
        m_dest  = h.d;
        m_val   = h.v;
        pend[h.d] = 0;
      end
      if (ok_iss) pend[iss_dest] = 1;
      if (acc) begin
        mq.push_back('{d: res_dest, v: res_val});
        if (res_dest != 0) sbq.push_back('{d: res_dest, v: res_val});
      end
    end
  end

  res_t e;
  always @(negedge clk) begin
    if (armed) begin
      chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
      chk("res_ready", 32'(res_ready), 32'(mq.size() < DEPTH));
      chk("hazard", 32'(hazard),
          32'(m_haz(pend, iss_wr, iss_dest, iss_src1, iss_src2)));
      chk("write_enable", 32'(write_enable), 32'(m_we));
      chk("dest", 32'(dest), 32'(m_dest));
      chk("destVal", destVal, m_val);
      if (write_enable === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_write", 32'(1), 32'(0));
        end else begin
          e = sbq.pop_front();
          chk("sb_dest", 32'(dest), 32'(e.d));
          chk("sb_val", destVal, e.v);
        end
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    iss_valid = 0; iss_wr = 0;
    iss_dest = '0; iss_src1 = '0; iss_src2 = '0;
    res_valid = 0; res_dest = '0; res_val = '0;
  endtask

  task automatic push(logic [AW-1:0] d, logic [DW-1:0] v);
    res_valid = 1; res_dest = d; res_val = v;
  endtask

  task automatic issue(logic [AW-1:0] d);
    iss_valid = 1; iss_wr = 1; iss_dest = d;
  endtask

  initial begin
    idle();
    rst_n = 0;
    push(5'd3, 32'h1111_2222);
    step(2);
    chk("rst_we", 32'(write_enable), 32'(0));
    chk("rst_count", 32'(fifo_count), 32'(0));
    chk("rst_hazard", 32'(hazard), 32'(0));
    chk("rst_ready", 32'(res_ready), 32'(1));
    rst_n = 1;
    push(5'd9, 32'h0000_1234);
    step();
    idle();
    step();
    chk("first_we", 32'(write_enable), 32'(1));
    chk("first_dest", 32'(dest), 32'(9));
    chk("first_val", destVal, 32'h0000_1234);
    step();

    issue(5'd5);
    step();
    idle();
    iss_src1 = 5'd5;
    #1 chk("raw_haz", 32'(hazard), 32'(1));
    step(2);
    chk("raw_haz_hold", 32'(hazard), 32'(1));
    push(5'd5, 32'hDEAD_BEEF);
    step();
    res_valid = 0;
    #1 chk("raw_haz_n", 32'(hazard), 32'(1));
    step();
    chk("raw_we", 32'(write_enable), 32'(1));
    chk("raw_dest", 32'(dest), 32'(5));
    chk("raw_val", destVal, 32'hDEAD_BEEF);
    chk("raw_haz_drop", 32'(hazard), 32'(0));
    step();
    chk("raw_we_once", 32'(write_enable), 32'(0));
    idle();

    issue(5'd0);
    #1 chk("r0_haz", 32'(hazard), 32'(0));
    step();
    idle();
    push(5'd0, 32'hCAFE_0000);
    step();
    res_valid = 0;
    step();
    chk("r0_we", 32'(write_enable), 32'(0));
    chk("r0_count", 32'(fifo_count), 32'(0));
    step();

    for (int i = 0; i < 5; i++) begin
      push(AW'(10 + i), $urandom);
      step();
    end
    idle();
    step(6);

    issue(5'd7);
    step();
    issue(5'd7);
    #1 chk("waw_haz", 32'(hazard), 32'(1));
    step();
    chk("waw_haz_hold", 32'(hazard), 32'(1));
    iss_valid = 0;
    push(5'd7, 32'h7777_0007);
    step();
    res_valid = 0;
    step();
    issue(5'd7);
    #1 chk("waw_free", 32'(hazard), 32'(0));
    step();
    iss_valid = 0;
    #1 chk("waw_reset", 32'(hazard), 32'(1));
    push(5'd7, 32'h7777_0008);
    step();
    idle();
    step(3);

    issue(5'd3);
    step();
    issue(5'd4);
    step();
    iss_valid = 0;
    iss_wr = 0;
    for (int i = 0; i < 3; i++) begin
      push(AW'(20 + i), $urandom);
      step();
    end
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
    iss_src1 = 5'd3;
    iss_src2 = 5'd4;
    #1 chk("mid_rst_haz", 32'(hazard), 32'(0));
    chk("mid_rst_count", 32'(fifo_count), 32'(0));
    step(3);
    chk("mid_rst_we", 32'(write_enable), 32'(0));
    idle();

    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      iss_valid = $urandom_range(0, 1);
      iss_wr    = $urandom_range(0, 1);
      iss_dest  = AW'($urandom_range(0, 7));
      iss_src1  = AW'($urandom_range(0, 7));
      iss_src2  = AW'($urandom_range(0, 7));
      res_valid = $urandom_range(0, 1);
      res_dest  = AW'($urandom_range(0, 7));
      res_val   = $urandom;
      step();
    end
    rst_n = 1;
    idle();
    step(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
Writer-side companion to the register file. It accepts execute-stage results through a valid/ready handshake and buffers them in a small FIFO. It drains one result per cycle onto the register file write port (write_enable/dest/destVal), whose writes land on the falling edge. It also keeps a per-register pending scoreboard so decode can stall on RAW and WAW hazards until the write has retired.

Parameters:
DEPTH, 4, result FIFO entries (power of 2, >=2)
ADDR_W, 5, register index width (32 registers)
DATA_W, 32, register data width

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
iss_valid  in  1  decode issues an instruction this cycle
iss_wr  in  1  issuing instruction writes a register
iss_dest  in  ADDR_W  destination of issuing instruction
iss_src1  in  ADDR_W  source 1 of instruction in decode
iss_src2  in  ADDR_W  source 2 of instruction in decode
hazard  out  1  combinational stall request to decode
res_valid  in  1  execute result available
res_ready  out  1  FIFO can accept a result
res_dest  in  ADDR_W  result destination register
res_val  in  DATA_W  result value
write_enable  out  1  register file write strobe (registered)
dest  out  ADDR_W  register file write index (registered)
destVal  out  DATA_W  register file write data (registered)
fifo_count  out  log2(DEPTH)+1  occupancy

Behaviour:
- Reset (rst_n=0 at posedge): FIFO pointers and count=0, all pending bits=0, write_enable=0, dest=0, destVal=0. Queued results are discarded. hazard=0 and res_ready=1 in the cycle after reset.
- Scoreboard: pending[31:1] bits. r0 is never pending.
- hazard = (iss_src1!=0 && pending[iss_src1]) | (iss_src2!=0 && pending[iss_src2]) | (iss_wr && iss_dest!=0 && pending[iss_dest]).
- Issue: on posedge with iss_valid=1, hazard=0, iss_wr=1 and iss_dest!=0, set pending[iss_dest]. iss_valid while hazard=1 is ignored with no state change.
- Push: res_ready = (count < DEPTH). A push occurs when res_valid && res_ready. A full FIFO refuses the push even if a pop happens in the same cycle.
- Pop: on each posedge with count>0, pop the head entry.
  - Register write_enable=1 (0 if the head dest is 0), dest=head dest, destVal=head value.
  - Clear pending[head dest] at the same edge.
  - If count=0, write_enable=0. dest/destVal hold their last value.
- Simultaneous push and pop: both take effect and count is unchanged. Pointers wrap modulo DEPTH.
- Latency: a result pushed at edge N pops at edge N+1, so write_enable is high for the cycle N+1..N+2. The register file commits it on that cycle's negedge, and a decode read at edge N+2 sees the new value.
- hazard for that register drops in the cycle after edge N+1. The dependent issue proceeds at edge N+2, coincident with the read.
- Clear vs set on the same register at the same edge cannot occur, because hazard blocks the issue. A one-cycle bubble is accepted.
- A result whose dest is not pending is still written. Its clear is a no-op.
- Results drain strictly in FIFO order. No bypass path.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with res_valid=1 -> write_enable=0, fifo_count=0, hazard=0, res_ready=1; after release, the first push goes through normally.
- RAW stall:
  - Stimulus: issue iss_wr=1, iss_dest=5; next cycle iss_src1=5.
  - Response: hazard=1 until res_dest=5, res_val=32'hDEADBEEF is pushed and popped; write_enable=1, dest=5, destVal=32'hDEADBEEF for exactly one cycle; hazard=0 the following cycle.
- r0 handling: issue iss_dest=0 then push res_dest=0 -> hazard never asserts, pop occurs, write_enable stays 0.
- Full FIFO (DEPTH=4):
  - Stimulus: push 5 consecutive results while the pop path drains.
  - Response: FIFO never exceeds 4 entries; write_enable pulses in push order with the correct dest/destVal; res_ready=0 whenever fifo_count=4.
- WAW: pending r7, issue with iss_wr=1, iss_dest=7, iss_src1=iss_src2=0 -> hazard=1, no state change; after writeback of r7, the same issue is accepted.
- Mid-operation reset: with 3 entries queued and r3/r4 pending, assert rst_n=0 for one cycle -> fifo_count=0, pending cleared, no further write_enable pulses.
